oled_digit_formatter: RTL and testbench

OLED_DIGIT_FORMATTER -- requirements
Module: oled_digit_formatter

---
 rtl/oled_pkg.sv | 38 +++
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/oled_digit_formatter.sv | 197 +++++++++++++++++++
 tb/tb_oled_digit_formatter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared constants and types for the OLED digit formatter
//
// Purpose: resource codes, block index/code widths, converter step count and
// the formatter state type, shared by oled_digit_formatter and bin2bcd_seq.
// Ports: none (package).
package oled_pkg;

  localparam int BLK_INDEX_W = 4;
  localparam int CODE_W      = 5;
  localparam int BCD_STEPS   = 16;

  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd10;

  // Resource codes for the decimal glyphs 0..9.
  localparam logic [CODE_W-1:0] CODE_DIGIT [10] = '{
    5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9
  };

  localparam logic [15:0] VALUE_MAX = 16'd9999;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  // Map one BCD digit to its glyph code, or to the blank glyph when it is a
  // leading zero. Non-decimal nibbles cannot come out of the converter, but
  // they map to blank rather than to a bogus glyph.
  function automatic logic [CODE_W-1:0] digit_code(input logic [3:0] bcd,
                                                   input logic       blank);
    if (blank || (bcd > 4'd9)) begin
      return CODE_BLANK;
    end
    return CODE_DIGIT[bcd];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter
//
// Purpose: double-dabble converter; one shift-add-3 step per clock, 16 steps
// per conversion. A start pulse loads the operand; done_o pulses for one cycle
// on the edge after the 16th step, with bcd_o holding the result.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   start_i  in   load bin_i and begin a conversion
//   bin_i    in   14-bit binary operand (<= 9999 for a 4-digit result)
//   done_o   out  one-cycle pulse, result valid on bcd_o
//   bcd_o    out  four BCD digits, most significant in [15:12]
module bin2bcd_seq
  import oled_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [13:0] bin_i,
  output logic        done_o,
  output logic [15:0] bcd_o
);

  logic [15:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic [15:0] bcd_adj;

  // Add-3 correction on every nibble that would overflow past 9 once doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The operand is zero-extended to 16 bits, so all 16 steps are shifts of
  // real data and the latency is fixed regardless of operand width.
  always_comb begin
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    running_d = running_q;
    done_d    = 1'b0;
    if (start_i) begin
      bin_d     = {2'b00, bin_i};
      bcd_d     = '0;
      cnt_d     = '0;
      running_d = 1'b1;
    end else if (running_q) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      cnt_d          = cnt_q + 4'd1;
      if (cnt_q == 4'(BCD_STEPS - 1)) begin
        running_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/oled_digit_formatter.sv
// rtl/oled_digit_formatter.sv - AHB slave that turns a number into four OLED digit block writes
//
// Purpose: a word-0 write supplies a value and a field number; the value is
// saturated to 9999, converted to BCD and emitted MSD first as four block
// writes (index = field*4 + digit) with leading zeros blanked. Word 1 reads
// {overrun, busy}; the read clears overrun.
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL, HREADY, HWRITE, HADDR, HWDATA, HTRANS   AHB slave inputs
//   HRDATA, HREADYOUT    AHB slave outputs (no wait states)
//   blk_valid, blk_index, blk_code   block write request to the OLED manager
//   blk_ready            OLED manager accepts the block write
module oled_digit_formatter
  import oled_pkg::*;
#(
  parameter int FIELD_COUNT = 4,
  parameter int DIGITS      = 4,
  parameter int CODE_WIDTH  = 5
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic                   HREADY,
  input  logic                   HWRITE,
  input  logic [31:0]            HADDR,
  input  logic [31:0]            HWDATA,
  input  logic [1:0]             HTRANS,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  output logic                   blk_valid,
  output logic [BLK_INDEX_W-1:0] blk_index,
  output logic [CODE_WIDTH-1:0]  blk_code,
  input  logic                   blk_ready
);

  localparam int FIELD_W = $clog2(FIELD_COUNT);

  // Registered AHB address phase.
  logic                   ph_valid_q, ph_valid_d;
  logic                   ph_write_q, ph_write_d;
  logic [1:0]             ph_addr_q,  ph_addr_d;

  state_e                 state_q, state_d;
  logic                   overrun_q, overrun_d;
  logic [FIELD_W-1:0]     field_q, field_d;
  logic [3:0][CODE_W-1:0] codes_q, codes_d;
  logic [1:0]             dig_q, dig_d;
  logic                   blk_valid_q, blk_valid_d;
  logic [BLK_INDEX_W-1:0] blk_index_q, blk_index_d;
  logic [CODE_W-1:0]      blk_code_q, blk_code_d;

  logic                   wr_word0, accept, drop, status_rd, busy;
  logic [13:0]            sat_value;
  logic                   bcd_start, bcd_done;
  logic [15:0]            bcd;
  logic [3:0][3:0]        bcd_digit;
  logic [2:0]             lead_zero;
  logic [3:0][CODE_W-1:0] new_codes;
  logic [1:0]             dig_next;
  logic                   unused_bits;

  function automatic logic [BLK_INDEX_W-1:0] block_of(input logic [FIELD_W-1:0] field,
                                                      input logic [1:0]         dig);
    return BLK_INDEX_W'(field) * BLK_INDEX_W'(DIGITS) + BLK_INDEX_W'(dig);
  endfunction

  assign busy      = (state_q != ST_IDLE);
  assign wr_word0  = ph_valid_q && ph_write_q && (ph_addr_q == 2'd0);
  assign accept    = wr_word0 && !busy;
  assign drop      = wr_word0 && busy;
  assign status_rd = ph_valid_q && !ph_write_q && (ph_addr_q == 2'd1);

  // Saturate before conversion so the converter only ever sees 4-digit values.
  assign sat_value = (HWDATA[15:0] > VALUE_MAX) ? VALUE_MAX[13:0] : HWDATA[13:0];
  assign bcd_start = accept;

  bin2bcd_seq u_bin2bcd (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .start_i (bcd_start),
    .bin_i   (sat_value),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  // Glyph codes for the fresh result; a digit is blanked only when it and
  // every digit to its left are zero, and the last digit always shows.
  always_comb begin
    bcd_digit[0] = bcd[15:12];
    bcd_digit[1] = bcd[11:8];
    bcd_digit[2] = bcd[7:4];
    bcd_digit[3] = bcd[3:0];
    lead_zero[0] = (bcd_digit[0] == 4'd0);
    lead_zero[1] = lead_zero[0] && (bcd_digit[1] == 4'd0);
    lead_zero[2] = lead_zero[1] && (bcd_digit[2] == 4'd0);
    new_codes[0] = digit_code(bcd_digit[0], lead_zero[0]);
    new_codes[1] = digit_code(bcd_digit[1], lead_zero[1]);
    new_codes[2] = digit_code(bcd_digit[2], lead_zero[2]);
    new_codes[3] = digit_code(bcd_digit[3], 1'b0);
  end

  assign dig_next = dig_q + 2'd1;

  always_comb begin
    ph_valid_d  = HREADY && HSEL && (HTRANS != 2'b00);
    ph_write_d  = HWRITE;
    ph_addr_d   = HADDR[3:2];
    state_d     = state_q;
    overrun_d   = overrun_q;
    field_d     = field_q;
    codes_d     = codes_q;
    dig_d       = dig_q;
    blk_valid_d = blk_valid_q;
    blk_index_d = blk_index_q;
    blk_code_d  = blk_code_q;

    if (status_rd) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          field_d = HWDATA[16 +: FIELD_W];
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (bcd_done) begin
          codes_d     = new_codes;
          dig_d       = 2'd0;
          blk_valid_d = 1'b1;
          blk_index_d = block_of(field_q, 2'd0);
          blk_code_d  = new_codes[0];
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (blk_valid_q && blk_ready) begin
          if (dig_q == 2'd3) begin
            blk_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            dig_d       = dig_next;
            blk_index_d = block_of(field_q, dig_next);
            blk_code_d  = codes_q[dig_next];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph_valid_q  <= 1'b0;
      ph_write_q  <= 1'b0;
      ph_addr_q   <= '0;
      state_q     <= ST_IDLE;
      overrun_q   <= 1'b0;
      field_q     <= '0;
      codes_q     <= '0;
      dig_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_index_q <= '0;
      blk_code_q  <= '0;
    end else begin
      ph_valid_q  <= ph_valid_d;
      ph_write_q  <= ph_write_d;
      ph_addr_q   <= ph_addr_d;
      state_q     <= state_d;
      overrun_q   <= overrun_d;
      field_q     <= field_d;
      codes_q     <= codes_d;
      dig_q       <= dig_d;
      blk_valid_q <= blk_valid_d;
      blk_index_q <= blk_index_d;
      blk_code_q  <= blk_code_d;
    end
  end

  // Read data is driven during the data phase straight from the registered
  // address phase, so it is zero whenever that phase is cleared by reset.
  assign HRDATA    = status_rd ? {30'b0, overrun_q, busy} : 32'b0;
  assign HREADYOUT = 1'b1;
  assign blk_valid = blk_valid_q;
  assign blk_index = blk_index_q;
  assign blk_code  = CODE_WIDTH'(blk_code_q);

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:16+FIELD_W]};

endmodule

// File: tb/tb_oled_digit_formatter.sv
// tb/tb_oled_digit_formatter.sv - scoreboard bench for oled_digit_formatter
module tb_oled_digit_formatter;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic        HREADY = 1'b1;
  logic        HWRITE = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [1:0]  HTRANS = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        blk_valid;
  logic [3:0]  blk_index;
  logic [4:0]  blk_code;
  logic        blk_ready = 1'b1;

  oled_digit_formatter #(
    .FIELD_COUNT (4),
    .DIGITS      (4),
    .CODE_WIDTH  (5)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HWRITE    (HWRITE),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HTRANS    (HTRANS),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .blk_valid (blk_valid),
    .blk_index (blk_index),
    .blk_code  (blk_code),
    .blk_ready (blk_ready)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [3:0] idx;
    logic [4:0] code;
  } xfer_t;

  xfer_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every transfer the DUT presents is popped against the scoreboard.
  always @(negedge HCLK) begin
    xfer_t e;
    if (HRESETn && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer: got index %0d code %0d required none", blk_index, blk_code);
      end else begin
        e = exp_q.pop_front();
        check("xfer_index", {28'b0, blk_index}, {28'b0, e.idx});
        check("xfer_code", {27'b0, blk_code}, {27'b0, e.code});
      end
    end
  end

  task automatic push_exp(input int field, input int c0, input int c1, input int c2, input int c3);
    int codes[4];
    xfer_t e;
    codes = '{c0, c1, c2, c3};
    for (int d = 0; d < 4; d++) begin
      e.idx  = 4'(field * 4 + d);
      e.code = 5'(codes[d]);
      exp_q.push_back(e);
    end
  endtask

  task automatic ahb_write(input logic [1:0] word, input logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'b0, word, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [1:0] word, output logic [31:0] data);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'b0, word, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!blk_valid && n < 64);
    if (!blk_valid) begin
      total++;
      bad++;
      $display("FAIL %s: got timeout required blk_valid", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || blk_valid) && n < 200) begin
      @(posedge HCLK); #1;
      n++;
    end
    if (exp_q.size() != 0 || blk_valid) begin
      total++;
      bad++;
      $display("FAIL %s: got %0d pending required 0", name, exp_q.size());
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          cap;

    repeat (3) @(posedge HCLK);
    #1;
    check("rst_valid", {31'b0, blk_valid}, 0);
    check("rst_index", {28'b0, blk_index}, 0);
    check("rst_code", {27'b0, blk_code}, 0);
    check("rst_hrdata", HRDATA, 0);
    check("rst_hreadyout", {31'b0, HREADYOUT}, 1);
    HRESETn = 1'b1;
    ahb_read(2'd1, rd);
    check("status_after_reset", rd, 0);

    // 1234 to field 1, ready held high: latency and back-to-back transfers.
    push_exp(1, 1, 2, 3, 4);
    ahb_write(2'd0, {14'b0, 2'd1, 16'd1234});
    cap = cyc;
    wait_valid("valid_1234");
    check("first_valid_latency", 32'(cyc - cap), 17);
    repeat (4) @(posedge HCLK);
    #1;
    check("b2b_four_cycles", {31'b0, blk_valid}, 0);
    ahb_read(2'd1, rd);
    check("status_idle_1234", rd, 0);
    wait_drain("drain_1234");

    // Leading-zero blanking, including the all-zero value.
    push_exp(0, 10, 10, 10, 7);
    ahb_write(2'd0, {14'b0, 2'd0, 16'd7});
    wait_drain("drain_7");
    push_exp(0, 10, 10, 10, 0);
    ahb_write(2'd0, 32'd0);
    wait_drain("drain_0");

    // Saturation to 9999.
    push_exp(3, 9, 9, 9, 9);
    ahb_write(2'd0, {14'b0, 2'd3, 16'd65535});
    wait_drain("drain_65535");

    // Back-pressure: stall on digit 1 for five cycles.
    blk_ready = 1'b0;
    push_exp(1, 5, 6, 7, 8);
    ahb_write(2'd0, {14'b0, 2'd1, 16'd5678});
    wait_valid("valid_5678");
    @(posedge HCLK); #1;
    blk_ready = 1'b1;
    @(posedge HCLK); #1;
    blk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      check("stall_valid", {31'b0, blk_valid}, 1);
      check("stall_index", {28'b0, blk_index}, 5);
      check("stall_code", {27'b0, blk_code}, 6);
    end
    @(posedge HCLK); #1;
    blk_ready = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check("stall_release_three_cycles", {31'b0, blk_valid}, 0);
    wait_drain("drain_5678");

    // Write while busy is dropped and flags overrun; reading clears it.
    push_exp(2, 4, 3, 2, 1);
    ahb_write(2'd0, {14'b0, 2'd2, 16'd4321});
    ahb_write(2'd0, {14'b0, 2'd0, 16'd9999});
    ahb_read(2'd1, rd);
    check("status_overrun_busy", rd, 3);
    ahb_read(2'd1, rd);
    check("status_overrun_cleared", rd, 1);
    wait_drain("drain_4321");
    ahb_read(2'd1, rd);
    check("status_after_overrun", rd, 0);

    // Other words: reads return 0, writes start nothing.
    ahb_read(2'd2, rd);
    check("read_word2", rd, 0);
    ahb_write(2'd1, 32'd1234);
    ahb_write(2'd3, 32'd1234);
    ahb_read(2'd1, rd);
    check("status_after_ignored_writes", rd, 0);
    repeat (25) @(posedge HCLK);
    #1;
    check("no_valid_after_ignored_writes", {31'b0, blk_valid}, 0);

    // Reset in the middle of Emit abandons the value.
    blk_ready = 1'b0;
    push_exp(0, 1, 1, 1, 1);
    ahb_write(2'd0, {14'b0, 2'd0, 16'd1111});
    wait_valid("valid_1111");
    #2;
    HRESETn = 1'b0;
    #1;
    check("midreset_valid", {31'b0, blk_valid}, 0);
    check("midreset_index", {28'b0, blk_index}, 0);
    check("midreset_code", {27'b0, blk_code}, 0);
    exp_q.delete();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    blk_ready = 1'b1;
    ahb_read(2'd1, rd);
    check("status_after_midreset", rd, 0);
    repeat (40) @(posedge HCLK);
    #1;
    check("no_valid_after_midreset", {31'b0, blk_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
